led_scan_ctrl: RTL and testbench
================================

Name: led_scan_ctrl

Overview:
Parametrised time-multiplexed 7-segment display driver for the clock project, the next generation of the 6-digit scan driver. It scans NUM_DIGITS common-anode digits at a programmable slot rate and blinks any subset of digits in setting mode. The per-digit blink mask replaces the single-position blink logic. It sits between the time/setting datapath (segment encoders, mode FSM) and the board's segment and enable pins.

Parameters:
NUM_DIGITS, 6, number of multiplexed digits (2..8)
SEG_W, 7, segment bits per digit (excluding dp)
SCAN_DIV, 5000, clk cycles per digit slot (>=2)
BLINK_FRAMES, 250, full scan frames per blink half-period (>=1)
GUARD_CYC, 8, blanking cycles at slot start when guard feature is compiled in (1..SCAN_DIV-1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
i_digit_seg  in  NUM_DIGITS*SEG_W  digit k segments at [k*SEG_W +: SEG_W], active-high
i_dp  in  NUM_DIGITS  decimal point of digit k, active-high
i_blink_mask  in  NUM_DIGITS  1 = digit k blinks when blinking is enabled
i_blink_en  in  1  blink enable (high in setting mode)
o_seg  out  SEG_W  segment drive of the currently selected digit
o_seg_dp  out  1  dp drive of the currently selected digit
o_seg_enb  out  NUM_DIGITS  digit enables, active-low, at most one bit low
o_frame_tick  out  1  one-cycle pulse at start of each scan frame

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low. All state is in clk-domain flops.
- Outputs on reset: o_seg=0, o_seg_dp=0, o_seg_enb=all 1s, o_frame_tick=0.
- Internal state on reset: prescaler=0, digit index=0, frame counter=0, blink phase=VISIBLE.
- Prescaler: counts 0..SCAN_DIV-1 and wraps. slot_end = (prescaler==SCAN_DIV-1).
- Digit index: on slot_end, index increments. It wraps from NUM_DIGITS-1 to 0. Each slot lasts exactly SCAN_DIV cycles.
- Frame counter: increments on each index wrap. When it reaches BLINK_FRAMES-1 together with a wrap, it clears to 0 and the blink phase toggles between VISIBLE and HIDDEN.
- Blink enable low: while i_blink_en=0, the frame counter is held at 0 and the phase is forced to VISIBLE. On a rising i_blink_en, every masked digit is therefore shown for a full half-period before its first HIDDEN phase.
- Blanked digit: digit k is blanked when i_blink_en=1, i_blink_mask[k]=1 and phase=HIDDEN. When blanked, o_seg=0 and o_seg_dp=0, while o_seg_enb[k] still asserts. The scan timing never changes.
- Output register: all outputs are registered. In each cycle they reflect the index, phase and inputs as sampled in the previous cycle (1-cycle latency).
  - o_seg_enb = ~(1<<index).
  - o_seg/o_seg_dp = digit[index] data, or 0 if that digit is blanked.
- o_frame_tick: high for exactly one cycle, the first cycle in which o_seg_enb selects digit 0 after a wrap. It does not assert for the first slot after reset.
- Input changes mid-slot: i_digit_seg, i_dp, i_blink_mask and i_blink_en changes take effect on the next clk. No snapshotting.
- Reset mid-slot: all outputs return to reset values immediately. Scanning restarts at digit 0 with a full slot after release.
- Width rules: the index is $clog2(NUM_DIGITS) bits, the prescaler $clog2(SCAN_DIV) bits, the frame counter $clog2(BLINK_FRAMES+1) bits. No arithmetic overflow is permitted.

Optional Feature:
- Macro: LED_SCAN_GUARD_EN.
- When defined: during prescaler values 0..GUARD_CYC-1 of every slot, o_seg_enb is forced to all 1s and o_seg/o_seg_dp to 0 (anti-ghosting dead time). The selected digit is lit only for SCAN_DIV-GUARD_CYC cycles per slot. o_frame_tick timing is unchanged, so it asserts during the guard cycle of digit 0.
- When undefined: no dead time, and the enable follows the index directly.

Test Plan:
Test parameters: NUM_DIGITS=4, SCAN_DIV=4, BLINK_FRAMES=2, GUARD_CYC=1.
1. Assert rst_n=0 mid-scan -> o_seg_enb=4'b1111, o_seg=0, o_seg_dp=0, o_frame_tick=0 immediately; after release, first enable 4'b1110 and slots last 4 cycles.
2. Free-run 64 cycles -> o_seg_enb cycles 1110, 1101, 1011, 0111 at 4 cycles each; o_frame_tick pulses every 16 cycles, aligned with the return to 1110.
3. i_digit_seg={7'h06,7'h5B,7'h4F,7'h66} (digits 3..0), i_dp=4'b0100 -> during digit0 o_seg=7'h66; during digit2 o_seg=7'h5B and o_seg_dp=1.
4. i_blink_en=1, i_blink_mask=4'b0010 -> digit1 shows data for 2 frames, then o_seg=0 for 2 frames (64-cycle blink period); digits 0, 2, 3 are never blanked.
5. Drop i_blink_en during the HIDDEN phase -> digit1 data is visible at its next slot; re-raise i_blink_en -> digit1 stays visible for a full 2 frames first.
6. Build with LED_SCAN_GUARD_EN -> the first cycle of every slot shows o_seg_enb=4'b1111 and o_seg=0, and the next 3 cycles show normal data; without the macro there are no all-off cycles.

Source files
------------

// File: rtl/led_scan_ctrl.sv
// led_scan_ctrl: time-multiplexed 7-segment scan driver with per-digit blink.
// Define LED_SCAN_GUARD_EN to add anti-ghosting dead time at each slot start.
module led_scan_ctrl #(
    parameter int NUM_DIGITS   = 6,
    parameter int SEG_W        = 7,
    parameter int SCAN_DIV     = 5000,
    parameter int BLINK_FRAMES = 250,
    parameter int GUARD_CYC    = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_DIGITS*SEG_W-1:0] i_digit_seg,
    input  logic [NUM_DIGITS-1:0]       i_dp,
    input  logic [NUM_DIGITS-1:0]       i_blink_mask,
    input  logic                        i_blink_en,
    output logic [SEG_W-1:0]            o_seg,
    output logic                        o_seg_dp,
    output logic [NUM_DIGITS-1:0]       o_seg_enb,
    output logic                        o_frame_tick
);

    localparam int IW = $clog2(NUM_DIGITS);
    localparam int PW = $clog2(SCAN_DIV);
    localparam int FW = $clog2(BLINK_FRAMES + 1);

    localparam logic [PW-1:0] PRE_LAST  = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);
    localparam logic [FW-1:0] FRM_LAST  = FW'(BLINK_FRAMES - 1);
    localparam logic [PW-1:0] GUARD_END = PW'(GUARD_CYC);

`ifdef LED_SCAN_GUARD_EN
    localparam logic GUARD_ON = 1'b1;
`else
    localparam logic GUARD_ON = 1'b0;
`endif

    typedef enum logic {
        VISIBLE = 1'b0,
        HIDDEN  = 1'b1
    } phase_t;

    logic [PW-1:0] presc;
    logic [IW-1:0] idx;
    logic [FW-1:0] frm;
    phase_t        phase;
    logic          wrap_q;

    logic                  slot_end;
    logic                  wrap;
    logic                  blanked;
    logic                  guard;
    logic [SEG_W-1:0]      seg_sel;
    logic                  dp_sel;
    logic                  mask_sel;
    logic [NUM_DIGITS-1:0] enb_sel;

    assign slot_end = (presc == PRE_LAST);
    assign wrap     = slot_end && (idx == IDX_LAST);

    // Digit mux is a one-hot compare so non-power-of-2 counts stay in range.
    always_comb begin
        seg_sel  = '0;
        dp_sel   = 1'b0;
        mask_sel = 1'b0;
        enb_sel  = '1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx == IW'(k)) begin
                seg_sel    = i_digit_seg[k*SEG_W +: SEG_W];
                dp_sel     = i_dp[k];
                mask_sel   = i_blink_mask[k];
                enb_sel[k] = 1'b0;
            end
        end
    end

    assign blanked = i_blink_en && mask_sel && (phase == HIDDEN);
    assign guard   = GUARD_ON && (presc < GUARD_END);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc  <= '0;
            idx    <= '0;
            frm    <= '0;
            phase  <= VISIBLE;
            wrap_q <= 1'b0;
        end else begin
            presc  <= slot_end ? '0 : presc + 1'b1;
            wrap_q <= wrap;
            if (slot_end) begin
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end
            // Holding at VISIBLE while disabled gives a full half-period on enable.
            if (!i_blink_en) begin
                frm   <= '0;
                phase <= VISIBLE;
            end else if (wrap) begin
                if (frm == FRM_LAST) begin
                    frm   <= '0;
                    phase <= (phase == VISIBLE) ? HIDDEN : VISIBLE;
                end else begin
                    frm <= frm + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_seg        <= '0;
            o_seg_dp     <= 1'b0;
            o_seg_enb    <= '1;
            o_frame_tick <= 1'b0;
        end else begin
            o_frame_tick <= wrap_q;
            if (guard) begin
                o_seg     <= '0;
                o_seg_dp  <= 1'b0;
                o_seg_enb <= '1;
            end else begin
                o_seg     <= blanked ? '0 : seg_sel;
                o_seg_dp  <= blanked ? 1'b0 : dp_sel;
                o_seg_enb <= enb_sel;
            end
        end
    end

endmodule

// File: tb/tb_led_scan_ctrl.sv
// tb_led_scan_ctrl: scoreboard bench for led_scan_ctrl (4 digits, div 4).
// Expected outputs come from a cycle-count model of the scan timing.
module tb_led_scan_ctrl;

    localparam int ND = 4;
    localparam int SW = 7;
    localparam int SD = 4;
    localparam int BF = 2;
    localparam int GC = 1;
    localparam int FR = SD * ND;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [ND*SW-1:0] digit_seg = '0;
    logic [ND-1:0]    dp = '0;
    logic [ND-1:0]    mask = '0;
    logic             blink_en = 1'b0;
    logic [SW-1:0]    seg;
    logic             seg_dp;
    logic [ND-1:0]    enb;
    logic             tick;

    always #5 clk = ~clk;

    led_scan_ctrl #(
        .NUM_DIGITS  (ND),
        .SEG_W       (SW),
        .SCAN_DIV    (SD),
        .BLINK_FRAMES(BF),
        .GUARD_CYC   (GC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_digit_seg (digit_seg),
        .i_dp        (dp),
        .i_blink_mask(mask),
        .i_blink_en  (blink_en),
        .o_seg       (seg),
        .o_seg_dp    (seg_dp),
        .o_seg_enb   (enb),
        .o_frame_tick(tick)
    );

    typedef struct packed {
        logic [ND-1:0] enb;
        logic [SW-1:0] seg;
        logic          dp;
        logic          tick;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   t = 0;
    int   ew = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        n_cmp++;
        assert (got === want) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    // Model: slot/digit from edge count, blink phase from wraps seen while enabled.
    always @(posedge clk) begin
        if (rst_n) begin
            exp_t e;
            int   k;
            logic hid;
            k = (t / SD) % ND;
            hid = ((ew / BF) % 2) == 1;
            e.enb = '1;
            e.enb[k] = 1'b0;
            e.seg = digit_seg[k*SW +: SW];
            e.dp = dp[k];
            if (blink_en && mask[k] && hid) begin
                e.seg = '0;
                e.dp = 1'b0;
            end
            e.tick = (t % FR == 0) && (t != 0);
`ifdef LED_SCAN_GUARD_EN
            if ((t % SD) < GC) begin
                e.enb = '1;
                e.seg = '0;
                e.dp = 1'b0;
            end
`endif
            sb.push_back(e);
            if (!blink_en) ew = 0;
            else if (t % FR == FR - 1) ew++;
            t++;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_enb", 32'(enb), 32'hF);
            chk("rst_seg", 32'(seg), 32'h0);
        end else if (sb.size() == 0) begin
            chk("sb_nonempty", 32'(sb.size()), 32'h1);
        end else begin
            exp_t e;
            e = sb.pop_front();
            chk("enb", 32'(enb), 32'(e.enb));
            chk("seg", 32'(seg), 32'(e.seg));
            chk("dp", 32'(seg_dp), 32'(e.dp));
            chk("tick", 32'(tick), 32'(e.tick));
        end
    end

    task automatic run(input int n);
        repeat (n) @(negedge clk);
        #2;
    endtask

    task automatic wait_sel(input logic [ND-1:0] want);
        int n;
        n = 0;
        @(negedge clk);
        while (enb !== want && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("sel_found", 32'(enb), 32'(want));
    endtask

    initial begin
        run(3);
        rst_n = 1'b1;
        run(10);

        // Mid-slot reset: outputs must clear without waiting for a clock.
        chk("pre_rst_enb_on", 32'(enb == 4'hF), 32'h0);
        rst_n = 1'b0;
        #1;
        chk("async_enb", 32'(enb), 32'hF);
        chk("async_seg", 32'(seg), 32'h0);
        chk("async_dp", 32'(seg_dp), 32'h0);
        chk("async_tick", 32'(tick), 32'h0);
        t = 0;
        ew = 0;
        run(3);
        rst_n = 1'b1;
        run(64);

        digit_seg = {7'h06, 7'h5B, 7'h4F, 7'h66};
        dp = 4'b0100;
        run(32);
        wait_sel(4'b1110);
        chk("d0_seg", 32'(seg), 32'h66);
        wait_sel(4'b1011);
        chk("d2_seg", 32'(seg), 32'h5B);
        chk("d2_dp", 32'(seg_dp), 32'h1);
        #2;

        blink_en = 1'b1;
        mask = 4'b0010;
        run(160);

        begin
            int n;
            n = 0;
            while (((ew / BF) % 2) == 0 && n < 100) begin
                run(1);
                n++;
            end
            chk("hidden_reached", 32'((ew / BF) % 2), 32'h1);
        end
        wait_sel(4'b1101);
        chk("d1_blank", 32'(seg), 32'h0);
        #2;
        blink_en = 1'b0;
        wait_sel(4'b1101);
        chk("d1_unblank", 32'(seg), 32'h4F);
        #2;
        run(20);
        blink_en = 1'b1;
        run(80);

        for (int i = 0; i < 8; i++) begin
            digit_seg = {$urandom, $urandom};
            dp = 4'($urandom);
            mask = 4'($urandom);
            run(3);
        end
        run(40);

        rst_n = 1'b0;
        #1;
        chk("end_rst_enb", 32'(enb), 32'hF);
        run(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
